// File: rtl/board_io_pkg.sv
// Shared register map and identification constants for the board I/O peripheral.
package board_io_pkg;

  localparam logic [3:0] ADDR_LED  = 4'd0;
  localparam logic [3:0] ADDR_SW   = 4'd1;
  localparam logic [3:0] ADDR_BTN  = 4'd2;
  localparam logic [3:0] ADDR_PEND = 4'd3;
  localparam logic [3:0] ADDR_MASK = 4'd4;
  localparam logic [3:0] ADDR_EDGE = 4'd5;
  localparam logic [3:0] ADDR_ID   = 4'd15;

  localparam logic [7:0] ID_MAGIC  = 8'hB1;

endpackage

// File: rtl/board_io_irq_btn_debounce.sv
// Single-button debouncer: a new level is accepted after 2**DEB_BITS-1 consecutive
// mismatching cycles; RISE/FALL pulse in the cycle STATE is about to change.
module btn_debounce #(
  parameter int DEB_BITS = 16
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic IN,
  output logic STATE,
  output logic RISE,
  output logic FALL
);

  // The count is accepted on the mismatch that would bring it to all-ones,
  // so the level flips on exactly the (2**DEB_BITS-1)th mismatching cycle.
  localparam logic [DEB_BITS-1:0] CNT_LAST = DEB_BITS'((2 ** DEB_BITS) - 2);

  logic [DEB_BITS-1:0] cnt_q;
  logic                state_q;
  logic                accept;

  assign accept = (IN != state_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else if (IN != state_q) begin
      if (accept) begin
        state_q <= IN;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign STATE = state_q;
  assign RISE  = accept & IN;
  assign FALL  = accept & ~IN;

endmodule

// File: rtl/board_io_irq.sv
// Memory-mapped board I/O: LED register, synchronised DIP switches, debounced
// buttons with per-button edge-select, mask and write-1-to-clear pending interrupts.
module board_io_irq
  import board_io_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int N_SW     = 4,
  parameter int N_LED    = 8,
  parameter int DEB_BITS = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             WE,
  input  logic [3:0]       A,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  output logic             INT,
  input  logic [N_BTN-1:0] BTNS,
  input  logic [N_SW-1:0]  DIP_SW,
  output logic [N_LED-1:0] LEDS
);

  // Bus: WE is a one-cycle write strobe qualified by A/WD at the rising CLK edge;
  // RD is a side-effect-free combinational read of the register selected by A.

  logic [N_BTN-1:0] btn_sync1_q, btn_sync2_q;
  logic [N_SW-1:0]  sw_sync1_q, sw_sync2_q;
  logic [N_LED-1:0] led_q;
  logic [N_BTN-1:0] pend_q, mask_q, edge_q;
  logic             int_q;
  logic [N_BTN-1:0] btn_state, btn_rise, btn_fall;
  logic [N_BTN-1:0] btn_event, pend_clr;
  logic             unused_wd;

  // Buttons are active-low on the board; inverted so 1 means pressed.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
    end else begin
      btn_sync1_q <= ~BTNS;
      btn_sync2_q <= btn_sync1_q;
      sw_sync1_q  <= DIP_SW;
      sw_sync2_q  <= sw_sync1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .IN      (btn_sync2_q[i]),
      .STATE   (btn_state[i]),
      .RISE    (btn_rise[i]),
      .FALL    (btn_fall[i])
    );
  end

  assign btn_event = (btn_rise & ~edge_q) | (btn_fall & edge_q);
  assign pend_clr  = (WE && (A == ADDR_PEND)) ? WD[N_BTN-1:0] : '0;

  // A new event wins over a same-cycle W1C of the same bit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      led_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
      int_q  <= 1'b0;
    end else begin
      if (WE && (A == ADDR_LED))  led_q  <= WD[N_LED-1:0];
      if (WE && (A == ADDR_MASK)) mask_q <= WD[N_BTN-1:0];
      if (WE && (A == ADDR_EDGE)) edge_q <= WD[N_BTN-1:0];
      pend_q <= (pend_q & ~pend_clr) | btn_event;
      int_q  <= |(pend_q & mask_q);
    end
  end

  always_comb begin
    RD = '0;
    case (A)
      ADDR_LED:  RD[N_LED-1:0] = led_q;
      ADDR_SW:   RD[N_SW-1:0]  = sw_sync2_q;
      ADDR_BTN:  RD[N_BTN-1:0] = btn_state;
      ADDR_PEND: RD[N_BTN-1:0] = pend_q;
      ADDR_MASK: RD[N_BTN-1:0] = mask_q;
      ADDR_EDGE: RD[N_BTN-1:0] = edge_q;
      ADDR_ID:   RD = {ID_MAGIC, 8'(N_LED), 8'(N_SW), 8'(N_BTN)};
      default:   RD = '0;
    endcase
  end

  assign unused_wd = ^WD;
  assign LEDS      = led_q;
  assign INT       = int_q;

endmodule

// File: tb/tb_board_io_irq.sv
// Directed and randomized bench for board_io_irq with a window-based reference model.
module tb_board_io_irq;

  localparam int N_BTN    = 4;
  localparam int N_SW     = 4;
  localparam int N_LED    = 8;
  localparam int DEB_BITS = 4;
  localparam int DEB_LEN  = 2 ** DEB_BITS - 1;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        WE;
  logic [3:0]  A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        INT;
  logic [3:0]  BTNS;
  logic [3:0]  DIP_SW;
  logic [7:0]  LEDS;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- clock / reset ----------------
  always #10 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  board_io_irq #(.N_BTN(N_BTN), .N_SW(N_SW), .N_LED(N_LED), .DEB_BITS(DEB_BITS)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .WE      (WE),
    .A       (A),
    .WD      (WD),
    .RD      (RD),
    .INT     (INT),
    .BTNS    (BTNS),
    .DIP_SW  (DIP_SW),
    .LEDS    (LEDS)
  );

  // ---------------- reference model ----------------
  // A button's accepted level flips when the last DEB_LEN samples seen by the
  // debouncer (raw level two cycles late) all disagree with the current level.
  logic [3:0]         m_bd0, m_bd1, m_sd0, m_sd1;
  logic [DEB_LEN-1:0] m_win   [N_BTN];
  logic [DEB_LEN-1:0] m_win_n [N_BTN];
  int                 m_nsamp, m_nsamp_n;
  logic [3:0]         m_btn, m_pend, m_mask, m_edge, m_flip, m_ev, m_clr, m_pend_n;
  logic [7:0]         m_led;
  logic               m_int;

  always_comb begin
    m_flip    = '0;
    m_ev      = '0;
    m_nsamp_n = (m_nsamp < DEB_LEN) ? m_nsamp + 1 : m_nsamp;
    for (int i = 0; i < N_BTN; i++) begin
      m_win_n[i] = {m_win[i][DEB_LEN-2:0], m_bd0[i]};
      m_flip[i]  = (m_nsamp_n >= DEB_LEN) && (m_win_n[i] == {DEB_LEN{~m_btn[i]}});
      m_ev[i]    = m_flip[i] && (m_edge[i] ? m_btn[i] : !m_btn[i]);
    end
    m_clr    = (WE && A == 4'd3) ? WD[3:0] : 4'd0;
    m_pend_n = (m_pend & ~m_clr) | m_ev;
  end

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_bd0 <= '0; m_bd1 <= '0; m_sd0 <= '0; m_sd1 <= '0;
      m_btn <= '0; m_pend <= '0; m_mask <= '0; m_edge <= '0;
      m_led <= '0; m_int <= 1'b0; m_nsamp <= 0;
      for (int i = 0; i < N_BTN; i++) m_win[i] <= '0;
    end else begin
      m_bd1   <= ~BTNS;
      m_bd0   <= m_bd1;
      m_sd1   <= DIP_SW;
      m_sd0   <= m_sd1;
      m_nsamp <= m_nsamp_n;
      for (int i = 0; i < N_BTN; i++) m_win[i] <= m_win_n[i];
      m_btn   <= m_btn ^ m_flip;
      m_pend  <= m_pend_n;
      m_int   <= |(m_pend & m_mask);
      if (WE) begin
        case (A)
          4'd0:    m_led  <= WD[7:0];
          4'd4:    m_mask <= WD[3:0];
          4'd5:    m_edge <= WD[3:0];
          default: ;
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    A = addr;
    #1;
    check(tag, RD, exp);
  endtask

  task automatic check_cycle();
    check("int", {31'd0, INT}, {31'd0, m_int});
    check("leds", {24'd0, LEDS}, {24'd0, m_led});
    read_chk("btn", 4'd2, {28'd0, m_btn});
    read_chk("pend", 4'd3, {28'd0, m_pend});
  endtask

  task automatic check_regs();
    read_chk("rd_led", 4'd0, {24'd0, m_led});
    read_chk("rd_sw", 4'd1, {28'd0, m_sd0});
    read_chk("rd_mask", 4'd4, {28'd0, m_mask});
    read_chk("rd_edge", 4'd5, {28'd0, m_edge});
    read_chk("rd_id", 4'd15, 32'hB108_0404);
    read_chk("rd_unmapped", 4'd9, 32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic run(input int n);
    repeat (n) begin
      @(negedge CLK);
      check_cycle();
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    A  = addr;
    WD = data;
    WE = 1'b1;
    @(negedge CLK);
    WE = 1'b0;
    check_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET_N = 1'b0; WE = 1'b0; A = 4'd0; WD = 32'd0;
    BTNS = 4'h0; DIP_SW = 4'h0;
    repeat (3) @(negedge CLK);
    check("rst_leds", {24'd0, LEDS}, 32'd0);
    check("rst_int", {31'd0, INT}, 32'd0);
    read_chk("rst_btn", 4'd2, 32'd0);
    read_chk("rst_id", 4'd15, 32'hB108_0404);
    read_chk("rst_pend", 4'd3, 32'd0);

    // buttons held through reset get accepted and raise press events
    @(negedge CLK);
    RESET_N = 1'b1;
    run(20);
    read_chk("held_press_pend", 4'd3, 32'hF);
    BTNS = 4'hF;
    run(20);
    read_chk("release_no_pend", 4'd3, 32'hF);
    bus_write(4'd3, 32'hF);
    read_chk("w1c_all", 4'd3, 32'h0);

    // LED and switches
    bus_write(4'd0, 32'h1A5);
    check("led_a5", {24'd0, LEDS}, 32'hA5);
    read_chk("led_rd", 4'd0, 32'hA5);
    DIP_SW = 4'b1010;
    run(2);
    read_chk("sw_rd", 4'd1, 32'hA);
    check_regs();

    // glitchy press never accepted
    bus_write(4'd4, 32'h1);
    for (int k = 0; k < 40; k++) begin
      BTNS = (k % 10 == 9) ? 4'hF : 4'hE;
      run(1);
    end
    read_chk("glitch_btn", 4'd2, 32'h0);
    BTNS = 4'hF;
    run(4);

    // steady press: 2 sync cycles + 15 debounce cycles
    BTNS = 4'hE;
    run(16);
    read_chk("deb_early", 4'd2, 32'h0);
    run(1);
    read_chk("deb_exact", 4'd2, 32'h1);
    read_chk("press_pend", 4'd3, 32'h1);
    check("int_lag", {31'd0, INT}, 32'd0);
    run(1);
    check("int_set", {31'd0, INT}, 32'd1);
    bus_write(4'd3, 32'h1);
    read_chk("w1c_pend", 4'd3, 32'h0);
    run(1);
    check("int_clr", {31'd0, INT}, 32'd0);

    // release-edge on btn1 with mask off, then enable mask
    bus_write(4'd5, 32'h2);
    bus_write(4'd4, 32'h0);
    BTNS = 4'hC;
    run(20);
    read_chk("press1_no_pend", 4'd3, 32'h0);
    BTNS = 4'hE;
    run(20);
    read_chk("rel1_pend", 4'd3, 32'h2);
    check("rel1_int_masked", {31'd0, INT}, 32'd0);
    bus_write(4'd4, 32'h2);
    run(1);
    check("mask_int", {31'd0, INT}, 32'd1);

    // collision: W1C lands on the same edge as a new press
    bus_write(4'd3, 32'h2);
    bus_write(4'd4, 32'h1);
    BTNS = 4'hF;
    run(20);
    BTNS = 4'hE;
    run(20);
    read_chk("press0_pend", 4'd3, 32'h1);
    check("press0_int", {31'd0, INT}, 32'd1);
    BTNS = 4'hF;
    run(20);
    BTNS = 4'hE;
    run(16);
    bus_write(4'd3, 32'h1);
    read_chk("collide_pend", 4'd3, 32'h1);
    check("collide_int", {31'd0, INT}, 32'd1);
    run(2);
    check("collide_int_hold", {31'd0, INT}, 32'd1);

    // reset in the middle of a debounce count
    BTNS = 4'hF;
    run(20);
    BTNS = 4'h0;
    run(8);
    RESET_N = 1'b0;
    #1;
    check("midrst_leds", {24'd0, LEDS}, 32'd0);
    check("midrst_int", {31'd0, INT}, 32'd0);
    read_chk("midrst_btn", 4'd2, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    run(16);
    read_chk("midrst_not_yet", 4'd2, 32'h0);
    run(4);
    read_chk("midrst_reaccept", 4'd3, 32'hF);
    check_regs();

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 24) == 0) BTNS = 4'($urandom);
      if ($urandom_range(0, 49) == 0) DIP_SW = 4'($urandom);
      case ($urandom_range(0, 15))
        0: bus_write(4'd3, $urandom);
        1: bus_write(4'd4, $urandom);
        2: bus_write(4'd5, $urandom);
        3: bus_write(4'd0, $urandom);
        4: bus_write(4'($urandom_range(1, 2)), $urandom);
        5: begin run(1); check_regs(); end
        default: run(1);
      endcase
    end
    check_regs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
